rr_mux_arbiter: RTL and testbench

//  Round-robin arbiter sharing one mux/demux datapath among N = 2**SEL_BITS requesters.

---
 rtl/rr_mux_arbiter.sv | 122 ++++++++++++
 tb/tb_rr_mux_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin owner selection for a shared mux/demux datapath.
// The owner's grant is cut off after MAX_HOLD cycles. Between owners there is always
// a dead gap so that the datapath select never changes while a transfer is in flight.
module rr_mux_arbiter #(
    parameter int SEL_BITS = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [(2**SEL_BITS)-1:0] req,
    output logic [(2**SEL_BITS)-1:0] grant,
    output logic [SEL_BITS-1:0]      sel,
    output logic                     busy,
    output logic                     preempt
);

    localparam int N     = 2 ** SEL_BITS;
    localparam int CNT_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [N-1:0]        grant_n;
    logic [SEL_BITS-1:0] sel_n;
    logic                busy_n;
    logic                preempt_n;
    logic [SEL_BITS-1:0] ptr, ptr_n;
    logic [CNT_W-1:0]    hold_cnt, hold_cnt_n;

    logic [SEL_BITS-1:0] winner;
    logic [SEL_BITS-1:0] cand;
    logic                found;
    logic                release_hit;
    logic                timeout_hit;

    // Find the first requester at or after ptr, scanning upward and wrapping at N-1.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + SEL_BITS'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // Exit conditions for the current owner. When both fire together, release wins.
    always_comb begin
        release_hit = (req[sel] == 1'b0);
        timeout_hit = (MAX_HOLD != 0) && (hold_cnt == CNT_W'(MAX_HOLD));
    end

    // Next-state and next-output logic. Every output is registered from these values.
    always_comb begin
        state_n    = state;
        grant_n    = grant;
        sel_n      = sel;
        busy_n     = busy;
        preempt_n  = 1'b0;
        ptr_n      = ptr;
        hold_cnt_n = hold_cnt;
        case (state)
            IDLE: begin
                if (req != '0) begin
                    state_n    = GRANT;
                    sel_n      = winner;
                    grant_n    = N'(1) << winner;
                    busy_n     = 1'b1;
                    hold_cnt_n = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_hit || timeout_hit) begin
                    state_n   = GAP;
                    grant_n   = '0;
                    busy_n    = 1'b0;
                    ptr_n     = sel + SEL_BITS'(1);
                    preempt_n = !release_hit;
                end else if (hold_cnt != '1) begin
                    hold_cnt_n = hold_cnt + CNT_W'(1);
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
                busy_n  = 1'b0;
            end
        endcase
    end

    // State and output registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            preempt  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            sel      <= sel_n;
            busy     <= busy_n;
            preempt  <= preempt_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_cnt_n;
        end
    end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// tb_rr_mux_arbiter: directed checks of rr_mux_arbiter with MAX_HOLD=8 and MAX_HOLD=0.
module tb_rr_mux_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       preempt;

    logic [3:0] req_u;
    logic [3:0] grant_u;
    logic [1:0] sel_u;
    logic       busy_u;
    logic       preempt_u;

    int checks   = 0;
    int failures = 0;

    rr_mux_arbiter #(.SEL_BITS(2), .MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .sel     (sel),
        .busy    (busy),
        .preempt (preempt)
    );

    rr_mux_arbiter #(.SEL_BITS(2), .MAX_HOLD(0)) dut_unl (
        .clk     (clk),
        .rst     (rst),
        .req     (req_u),
        .grant   (grant_u),
        .sel     (sel_u),
        .busy    (busy_u),
        .preempt (preempt_u)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic [3:0] g, input logic [1:0] s,
                            input logic b, input logic p);
        checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
        checkOutput({tag, ".sel"}, 32'(sel), 32'(s));
        checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
        checkOutput({tag, ".preempt"}, 32'(preempt), 32'(p));
    endtask

    // Directed sequence of steps with hand-computed expectations.
    initial begin
        logic [3:0] owner_oh;
        int owners [5] = '{0, 1, 2, 3, 0};

        rst   = 1'b1;
        req   = 4'b0000;
        req_u = 4'b0000;
        stepClock();
        stepClock();
        checkAll("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;

        // Single requester 2, released after four grant cycles
        applyStimulus(4'b0100);
        stepClock();
        checkAll("single_e1", 4'b0100, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            stepClock();
            checkAll("single_hold", 4'b0100, 2'd2, 1'b1, 1'b0);
        end
        applyStimulus(4'b0000);
        stepClock();
        checkAll("single_gap", 4'b0000, 2'd2, 1'b0, 1'b0);
        stepClock();
        checkAll("single_idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // Wrap fairness: ptr=3, req=1001 -> 3 first, then 0
        applyStimulus(4'b1001);
        stepClock();
        checkAll("wrap_first3", 4'b1000, 2'd3, 1'b1, 1'b0);
        stepClock();
        checkAll("wrap_hold3", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0001);
        stepClock();
        checkAll("wrap_gap", 4'b0000, 2'd3, 1'b0, 1'b0);
        stepClock();
        checkAll("wrap_idle", 4'b0000, 2'd3, 1'b0, 1'b0);
        stepClock();
        checkAll("wrap_then0", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000);
        stepClock();
        checkAll("wrap_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
        stepClock();

        // Async reset in the middle of a grant to requester 2 (ptr=1 -> skips 1, picks 2)
        applyStimulus(4'b0100);
        stepClock();
        checkAll("async_pre", 4'b0100, 2'd2, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        checkAll("async_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
        applyStimulus(4'b0001);
        #2;
        rst = 1'b0;
        stepClock();
        checkAll("async_after", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000);
        stepClock();
        stepClock();
        #3;
        rst = 1'b1;
        #2;
        rst = 1'b0;

        // Rotation with all requesting: 8-cycle grants, preempt pulse, two dead cycles
        applyStimulus(4'b1111);
        for (int k = 0; k < 5; k++) begin
            owner_oh = 4'b0001 << owners[k];
            for (int c = 0; c < 8; c++) begin
                stepClock();
                checkAll("rot_grant", owner_oh, 2'(owners[k]), 1'b1, 1'b0);
            end
            stepClock();
            checkAll("rot_preempt", 4'b0000, 2'(owners[k]), 1'b0, 1'b1);
            stepClock();
            checkAll("rot_idle", 4'b0000, 2'(owners[k]), 1'b0, 1'b0);
        end
        applyStimulus(4'b0000);

        // Release on the same edge as the timeout: no preempt, ptr advances to 2
        applyStimulus(4'b0010);
        for (int c = 0; c < 8; c++) begin
            stepClock();
            checkAll("simul_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        end
        applyStimulus(4'b0000);
        stepClock();
        checkAll("simul_exit", 4'b0000, 2'd1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0110);
        stepClock();
        checkAll("simul_ptr", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000);
        stepClock();
        stepClock();

        // Unlimited hold: grant never revoked across 100 cycles
        req_u = 4'b0010;
        for (int c = 0; c < 100; c++) begin
            stepClock();
            checkOutput("unl_grant", 32'(grant_u), 32'(4'b0010));
            checkOutput("unl_preempt", 32'(preempt_u), 32'(1'b0));
        end
        checkOutput("unl_sel", 32'(sel_u), 32'(2'd1));
        checkOutput("unl_busy", 32'(busy_u), 32'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
